// File: rtl/up_regfile_pkg.sv
// ---------------------------------------------------------------------------
// up_regfile_pkg
// Shared constants for the traffic generator/checker register bank:
// register word offsets (up_addr[7:2]), reset values, the default ID
// constant and CTRL bit positions.
// ---------------------------------------------------------------------------
package up_regfile_pkg;

  // Word offsets, i.e. byte offset >> 2
  localparam logic [5:0] OFF_ID      = 6'h00;  // 0x00
  localparam logic [5:0] OFF_CTRL    = 6'h01;  // 0x04
  localparam logic [5:0] OFF_PKT_LEN = 6'h02;  // 0x08
  localparam logic [5:0] OFF_PKT_NUM = 6'h03;  // 0x0C
  localparam logic [5:0] OFF_IFG     = 6'h04;  // 0x10
  localparam logic [5:0] OFF_SCRATCH = 6'h05;  // 0x14
  localparam logic [5:0] OFF_TX_CNT  = 6'h08;  // 0x20
  localparam logic [5:0] OFF_RX_CNT  = 6'h09;  // 0x24
  localparam logic [5:0] OFF_ERR_CNT = 6'h0A;  // 0x28

  localparam logic [31:0] ID_DEFAULT  = 32'h5453_4554;
  localparam logic [15:0] PKT_LEN_RST = 16'd64;
  localparam logic [31:0] PKT_NUM_RST = 32'd0;
  localparam logic [7:0]  IFG_RST     = 8'd12;

  localparam int CTRL_GEN_EN_BIT  = 0;
  localparam int CTRL_CHK_EN_BIT  = 1;
  localparam int CTRL_CNT_CLR_BIT = 2;

endpackage

// File: rtl/up_evt_counter.sv
// ---------------------------------------------------------------------------
// up_evt_counter
// 32-bit event counter that saturates at all-ones. Clear has priority over
// a coincident event.
// Ports:
//   up_clk  clock
//   up_rst  synchronous active-low reset
//   clr     synchronous clear (wins over evt)
//   evt     one-cycle event pulse
//   count   current count
// ---------------------------------------------------------------------------
module up_evt_counter (
  input  logic        up_clk,
  input  logic        up_rst,
  input  logic        clr,
  input  logic        evt,
  output logic [31:0] count
);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge up_clk) begin
    if (!up_rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (evt && (count != 32'hFFFF_FFFF)) begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/up_regfile.sv
// ---------------------------------------------------------------------------
// up_regfile
// Register bank on the tester CPU bus. Decodes up_wr/up_rd, holds the
// traffic generator/checker control registers, counts tx/rx/error events
// in saturating counters and returns registered read data one cycle after
// the read strobe.
//
// Build option: define UP_REGFILE_SNAPSHOT_EN to make a read of TX_CNT
// snapshot all three counters; RX_CNT/ERR_CNT reads then return the
// snapshot. Without it every counter read is live.
//
// Ports:
//   up_clk, up_rst               clock, synchronous active-low reset
//   up_wr, up_rd                 write / read strobes (write wins if both)
//   up_addr, up_data_wr          byte address, write data
//   up_data_rd, up_wait          registered read data, busy (= up_rd)
//   tx/rx_pkt_evt, rx_err_evt    event pulses into the counters
//   gen_en, chk_en, cnt_clr      CTRL outputs (cnt_clr is a 1-cycle pulse)
//   pkt_len, pkt_num, ifg_len    generator configuration
// ---------------------------------------------------------------------------
module up_regfile
  import up_regfile_pkg::*;
#(
  parameter logic [23:0] BASE_ADDR = 24'h000000,
  parameter logic [31:0] ID_VALUE  = ID_DEFAULT
) (
  input  logic        up_clk,
  input  logic        up_rst,
  input  logic        up_wr,
  input  logic        up_rd,
  input  logic [31:0] up_addr,
  input  logic [31:0] up_data_wr,
  output logic [31:0] up_data_rd,
  output logic        up_wait,
  input  logic        tx_pkt_evt,
  input  logic        rx_pkt_evt,
  input  logic        rx_err_evt,
  output logic        gen_en,
  output logic        chk_en,
  output logic        cnt_clr,
  output logic [15:0] pkt_len,
  output logic [31:0] pkt_num,
  output logic [7:0]  ifg_len
);

  logic        hit;
  logic [5:0]  word;
  logic        rd_only;
  logic [31:0] scratch;
  logic [31:0] tx_cnt, rx_cnt, err_cnt;
  logic [31:0] rx_rd_val, err_rd_val;
  logic [31:0] rd_mux;
  logic        unused_addr_lsb;

  assign hit     = (up_addr[31:8] == BASE_ADDR);
  assign word    = up_addr[7:2];
  assign rd_only = up_rd && !up_wr;   // a coincident write suppresses the read
  assign unused_addr_lsb = ^up_addr[1:0];

  // Busy only during the strobe cycle; held low while in reset.
  assign up_wait = up_rd && up_rst;

  up_evt_counter u_tx_cnt  (.up_clk(up_clk), .up_rst(up_rst), .clr(cnt_clr),
                            .evt(tx_pkt_evt), .count(tx_cnt));
  up_evt_counter u_rx_cnt  (.up_clk(up_clk), .up_rst(up_rst), .clr(cnt_clr),
                            .evt(rx_pkt_evt), .count(rx_cnt));
  up_evt_counter u_err_cnt (.up_clk(up_clk), .up_rst(up_rst), .clr(cnt_clr),
                            .evt(rx_err_evt), .count(err_cnt));

`ifdef UP_REGFILE_SNAPSHOT_EN
  // The TX_CNT read itself returns the live tx count, which is exactly the
  // value captured at that instant, so only rx/err need shadow storage.
  logic [31:0] rx_shadow, err_shadow;

  always_ff @(posedge up_clk) begin
    if (!up_rst || cnt_clr) begin
      rx_shadow  <= '0;
      err_shadow <= '0;
    end else if (rd_only && hit && (word == OFF_TX_CNT)) begin
      rx_shadow  <= rx_cnt;
      err_shadow <= err_cnt;
    end
  end

  assign rx_rd_val  = rx_shadow;
  assign err_rd_val = err_shadow;
`else
  assign rx_rd_val  = rx_cnt;
  assign err_rd_val = err_cnt;
`endif

  // NOTE: every always_comb output gets a default first, so no path through
  // the case can leave it unassigned and infer a latch.
  always_comb begin
    rd_mux = '0;
    if (hit) begin
      case (word)
        OFF_ID:      rd_mux = ID_VALUE;
        OFF_CTRL:    rd_mux = {30'd0, chk_en, gen_en};
        OFF_PKT_LEN: rd_mux = {16'd0, pkt_len};
        OFF_PKT_NUM: rd_mux = pkt_num;
        OFF_IFG:     rd_mux = {24'd0, ifg_len};
        OFF_SCRATCH: rd_mux = scratch;
        OFF_TX_CNT:  rd_mux = tx_cnt;
        OFF_RX_CNT:  rd_mux = rx_rd_val;
        OFF_ERR_CNT: rd_mux = err_rd_val;
        default:     rd_mux = '0;
      endcase
    end
  end

  always_ff @(posedge up_clk) begin
    if (!up_rst) begin
      up_data_rd <= '0;
      gen_en     <= 1'b0;
      chk_en     <= 1'b0;
      cnt_clr    <= 1'b0;
      pkt_len    <= PKT_LEN_RST;
      pkt_num    <= PKT_NUM_RST;
      ifg_len    <= IFG_RST;
      scratch    <= '0;
    end else begin
      cnt_clr <= 1'b0;
      if (up_wr && hit) begin
        case (word)
          OFF_CTRL: begin
            gen_en  <= up_data_wr[CTRL_GEN_EN_BIT];
            chk_en  <= up_data_wr[CTRL_CHK_EN_BIT];
            cnt_clr <= up_data_wr[CTRL_CNT_CLR_BIT];
          end
          OFF_PKT_LEN: pkt_len <= up_data_wr[15:0];
          OFF_PKT_NUM: pkt_num <= up_data_wr;
          OFF_IFG:     ifg_len <= up_data_wr[7:0];
          OFF_SCRATCH: scratch <= up_data_wr;
          default: ;  // RO and unmapped offsets ignore writes
        endcase
      end
      if (rd_only) begin
        up_data_rd <= rd_mux;
      end
    end
  end

endmodule
